// File: rtl/load_store_unit.sv
// RV32I load/store sequencer in front of a single-port, word-wide data memory.
// Sub-word stores are performed as read-modify-write of the addressed word.

`ifndef _MEM_ADDR_WIDTH_
`define _MEM_ADDR_WIDTH_ 8
`endif
`ifndef _MEM_DATA_WIDTH_
`define _MEM_DATA_WIDTH_ 32
`endif
`ifndef _DATA_MEM_SIZE_
`define _DATA_MEM_SIZE_ 256
`endif

module load_store_unit #(
    parameter int MEM_ADDR_WIDTH = `_MEM_ADDR_WIDTH_,
    parameter int DATA_WIDTH     = `_MEM_DATA_WIDTH_,
    parameter int DATA_MEM_SIZE  = `_DATA_MEM_SIZE_
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_Valid,
    output logic                      o_Ready,
    input  logic                      i_IsStore,
    input  logic [2:0]                i_Funct3,
    input  logic [31:0]               i_Addr,
    input  logic [31:0]               i_StoreData,
    output logic                      o_Done,
    output logic [31:0]               o_LoadData,
    output logic                      o_Misaligned,
    output logic                      o_AccessFault,
    output logic [MEM_ADDR_WIDTH-1:0] o_MemAddr,
    output logic [DATA_WIDTH-1:0]     o_MemDataOut,
    output logic                      o_MemWrEn,
    input  logic [DATA_WIDTH-1:0]     i_MemDataIn
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] MEM_WORDS = 32'(DATA_MEM_SIZE);

    state_t state;
    state_t next_state;

    logic [MEM_ADDR_WIDTH+1:0] addr_q;
    logic [2:0]                funct3_q;
    logic [31:0]               sdata_q;
    logic                      store_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [31:0]               load_data_q;
    logic                      mis_q;
    logic                      af_q;

    logic accept;
    logic illegal;
    logic misaligned;
    logic out_of_range;
    logic fault_mis;
    logic fault_af;

    logic [DATA_WIDTH-1:0] rd_shift;
    logic [31:0]           load_ext;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] lane_data;
    logic [DATA_WIDTH-1:0] merged;

    // Request classification, evaluated on the live inputs at accept time.
    always_comb begin
        illegal = 1'b0;
        case (i_Funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = i_IsStore;
            default:          illegal = 1'b1;
        endcase
        misaligned = (((i_Funct3 == F3_H) || (i_Funct3 == F3_HU)) && i_Addr[0])
                   || ((i_Funct3 == F3_W) && (i_Addr[1:0] != 2'b00));
        out_of_range = {2'b00, i_Addr[31:2]} >= MEM_WORDS;
        fault_mis = !illegal && misaligned;
        fault_af  = illegal || (!misaligned && out_of_range);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        o_Ready    = 1'b0;
        o_Done     = 1'b0;
        o_MemWrEn  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                o_Ready = 1'b1;
                accept  = i_Valid;
                if (i_Valid) begin
                    if (fault_af || fault_mis) begin
                        next_state = RESP;
                    end else if (!i_IsStore) begin
                        next_state = LOAD;
                    end else if (i_Funct3 == F3_W) begin
                        next_state = WRITE;
                    end else begin
                        next_state = RMW_RD;
                    end
                end
            end
            LOAD:   next_state = RESP;
            RMW_RD: next_state = WRITE;
            WRITE: begin
                o_MemWrEn  = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                o_Done     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Lane extraction for loads; halves are aligned so the shift is 0 or 16.
    always_comb begin
        rd_shift = i_MemDataIn >> {addr_q[1:0], 3'b000};
        load_ext = rd_shift[31:0];
        case (funct3_q)
            F3_B:    load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            F3_BU:   load_ext = {24'd0, rd_shift[7:0]};
            F3_H:    load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            F3_HU:   load_ext = {16'd0, rd_shift[15:0]};
            default: load_ext = rd_shift[31:0];
        endcase
    end

    // Byte/half merge of the store data into the word read back in RMW_RD.
    always_comb begin
        lane_mask = DATA_WIDTH'(8'hFF) << {addr_q[1:0], 3'b000};
        lane_data = DATA_WIDTH'(sdata_q[7:0]) << {addr_q[1:0], 3'b000};
        if (funct3_q == F3_H) begin
            lane_mask = DATA_WIDTH'(16'hFFFF) << {addr_q[1:0], 3'b000};
            lane_data = DATA_WIDTH'(sdata_q[15:0]) << {addr_q[1:0], 3'b000};
        end
        merged = (i_MemDataIn & ~lane_mask) | (lane_data & lane_mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            funct3_q    <= '0;
            sdata_q     <= '0;
            store_q     <= 1'b0;
            wdata_q     <= '0;
            load_data_q <= '0;
            mis_q       <= 1'b0;
            af_q        <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= i_Addr[MEM_ADDR_WIDTH+1:0];
                funct3_q <= i_Funct3;
                sdata_q  <= i_StoreData;
                store_q  <= i_IsStore;
                if (i_IsStore && !fault_af && !fault_mis) begin
                    wdata_q <= DATA_WIDTH'(i_StoreData);
                end
            end
            if ((state == RMW_RD) && store_q) begin
                wdata_q <= merged;
            end
            // Result registers change only as o_Done rises, then hold.
            if (next_state == RESP) begin
                load_data_q <= (state == LOAD) ? load_ext : 32'd0;
                mis_q       <= (state == IDLE) && fault_mis;
                af_q        <= (state == IDLE) && fault_af;
            end
        end
    end

    assign o_MemAddr     = addr_q[MEM_ADDR_WIDTH+1:2];
    assign o_MemDataOut  = wdata_q;
    assign o_LoadData    = load_data_q;
    assign o_Misaligned  = mis_q;
    assign o_AccessFault = af_q;

endmodule
